// File: rtl/mem_xfer_pkg.sv
// Shared types for the two-bank memory transfer engine.
package mem_xfer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } xfer_state_t;

  localparam logic MODE_COPY = 1'b0;
  localparam logic MODE_ACC  = 1'b1;

endpackage

// File: rtl/mem_xfer_engine_bank.sv
// Single-port-write, registered-read memory bank; array and read register carry no reset.
module mem_bank #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // Write port and registered read port
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    o_rdata <= r_mem[i_raddr];
  end

endmodule

// File: rtl/mem_xfer_engine.sv
// Two-bank memory with an A->B block-transfer engine (copy or accumulate).
module mem_xfer_engine
  import mem_xfer_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic [AW-1:0]    AddrA,
  input  logic             WEA,
  input  logic [WIDTH-1:0] DataInA,
  input  logic [AW-1:0]    AddrB,
  output logic [WIDTH-1:0] DOutB,
  input  logic             start,
  input  logic [AW-1:0]    SrcAddr,
  input  logic [AW-1:0]    DstAddr,
  input  logic [AW:0]      Count,
  input  logic             Mode,
  output logic             busy,
  output logic             done
);

  localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] ONE_A   = AW'(1);
  localparam logic [AW:0]   ONE_C   = (AW+1)'(1);

  xfer_state_t      r_state;
  xfer_state_t      w_state_nxt;
  logic [AW-1:0]    r_src;
  logic [AW-1:0]    r_dst;
  logic [AW:0]      r_rem;
  logic             r_mode;
  logic             r_busy;
  logic             r_done;
  logic             r_host_sel;
  logic [WIDTH-1:0] r_hold;

  logic [AW:0]      w_count_clamp;
  logic [AW-1:0]    w_a_raddr;
  logic [AW-1:0]    w_b_raddr;
  logic             w_we_a;
  logic             w_we_b;
  logic [WIDTH-1:0] w_q_a;
  logic [WIDTH-1:0] w_q_b;
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_wdata_b;
  logic [WIDTH-1:0] w_dout;

  assign w_count_clamp = (Count > DEPTH_C) ? DEPTH_C : Count;
  // The first word's reads are launched on the start edge, so B writes land on odd edges
  assign w_a_raddr = (r_state == IDLE) ? SrcAddr : r_src;
  assign w_b_raddr = (r_state != IDLE) ? r_dst : (start ? DstAddr : AddrB);
  assign w_we_a    = WEA && (r_state == IDLE);
  assign w_we_b    = (r_state == RD);
  assign w_sum     = w_q_a + w_q_b;
  assign w_wdata_b = (r_mode == MODE_ACC) ? w_sum : w_q_a;
  // B's read register is shared with the engine, so the host value is shadowed while busy
  assign w_dout    = r_host_sel ? w_q_b : r_hold;

  assign DOutB = w_dout;
  assign busy  = r_busy;
  assign done  = r_done;

  mem_bank #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_bank_a (
    .i_clk   (clock),
    .i_we    (w_we_a),
    .i_waddr (AddrA),
    .i_wdata (DataInA),
    .i_raddr (w_a_raddr),
    .o_rdata (w_q_a)
  );

  mem_bank #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_bank_b (
    .i_clk   (clock),
    .i_we    (w_we_b),
    .i_waddr (r_dst),
    .i_wdata (w_wdata_b),
    .i_raddr (w_b_raddr),
    .o_rdata (w_q_b)
  );

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = (w_count_clamp == {(AW+1){1'b0}}) ? DONE : RD;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      RD:      w_state_nxt = WR;
      WR: begin
        if (r_rem == {(AW+1){1'b0}}) begin
          w_state_nxt = DONE;
        end else begin
          w_state_nxt = RD;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // State, transfer counters, status flags and host read shadow
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state    <= IDLE;
      r_src      <= {AW{1'b0}};
      r_dst      <= {AW{1'b0}};
      r_rem      <= {(AW+1){1'b0}};
      r_mode     <= MODE_COPY;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_host_sel <= 1'b0;
      r_hold     <= {WIDTH{1'b0}};
    end else begin
      r_state    <= w_state_nxt;
      r_busy     <= (w_state_nxt != IDLE);
      r_done     <= (w_state_nxt == DONE);
      r_host_sel <= (r_state == IDLE) && !start;
      r_hold     <= w_dout;
      if ((r_state == IDLE) && start) begin
        r_src  <= SrcAddr;
        r_dst  <= DstAddr;
        r_rem  <= w_count_clamp;
        r_mode <= Mode;
      end else if (r_state == RD) begin
        r_src <= r_src + ONE_A;
        r_dst <= r_dst + ONE_A;
        r_rem <= r_rem - ONE_C;
      end
    end
  end

endmodule

// File: tb/tb_mem_xfer_engine.sv
// Directed, table-driven bench for mem_xfer_engine (WIDTH=8, DEPTH=4).
module tb_mem_xfer_engine;

  logic       clock;
  logic       resetn;
  logic [1:0] AddrA;
  logic       WEA;
  logic [7:0] DataInA;
  logic [1:0] AddrB;
  logic [7:0] DOutB;
  logic       start;
  logic [1:0] SrcAddr;
  logic [1:0] DstAddr;
  logic [2:0] Count;
  logic       Mode;
  logic       busy;
  logic       done;

  int n_cmp = 0;
  int n_bad = 0;
  int done_pulses = 0;

  mem_xfer_engine #(.WIDTH(8), .DEPTH(4)) dut (
    .clock   (clock),
    .resetn  (resetn),
    .AddrA   (AddrA),
    .WEA     (WEA),
    .DataInA (DataInA),
    .AddrB   (AddrB),
    .DOutB   (DOutB),
    .start   (start),
    .SrcAddr (SrcAddr),
    .DstAddr (DstAddr),
    .Count   (Count),
    .Mode    (Mode),
    .busy    (busy),
    .done    (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (resetn && done) done_pulses++;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running, required to finish");
    $fatal(1);
  end

  typedef struct {
    logic [31:0] a;
    logic [1:0]  src;
    logic [1:0]  dst;
    logic [2:0]  cnt;
    logic        mode;
    int          exp_edge;
    logic [31:0] exp_b;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic write_a(input logic [1:0] a, input logic [7:0] d);
    @(negedge clock);
    AddrA = a; DataInA = d; WEA = 1'b1;
    @(posedge clock);
    @(negedge clock);
    WEA = 1'b0;
  endtask

  task automatic read_b(input logic [1:0] a, output logic [7:0] q);
    @(negedge clock);
    AddrB = a;
    @(posedge clock);
    @(negedge clock);
    q = DOutB;
  endtask

  // Returns the index of the edge (start edge = 0) after which done was seen
  task automatic run_xfer(input logic [1:0] s, input logic [1:0] d, input logic [2:0] c,
                          input logic m, output int edge_idx);
    @(negedge clock);
    SrcAddr = s; DstAddr = d; Count = c; Mode = m; start = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    edge_idx = 0;
    while (!done && edge_idx < 40) begin
      @(posedge clock);
      @(negedge clock);
      edge_idx++;
    end
    check("busy_at_done", {31'd0, busy}, 32'd1);
  endtask

  initial begin
    logic [31:0] w;
    logic [7:0]  q;
    int          e;
    int          p0;
    int          dout_changes;

    resetn = 1'b0; AddrA = 2'd0; WEA = 1'b0; DataInA = 8'd0; AddrB = 2'd0;
    start = 1'b0; SrcAddr = 2'd0; DstAddr = 2'd0; Count = 3'd0; Mode = 1'b0;

    // a, src, dst, cnt, mode, done edge, expected B (byte i = word i)
    vecs[0] = '{32'h2004_01FF, 2'd0, 2'd0, 3'd4, 1'b0, 8, 32'h2004_01FF};
    vecs[1] = '{32'h4030_2010, 2'd3, 2'd2, 3'd3, 1'b0, 6, 32'h1040_0120};
    vecs[2] = '{32'h4030_20F0, 2'd0, 2'd0, 3'd1, 1'b0, 2, 32'h1040_01F0};
    vecs[3] = '{32'h4030_2020, 2'd0, 2'd0, 3'd1, 1'b1, 2, 32'h1040_0110};
    vecs[4] = '{32'hDDCC_BBAA, 2'd1, 2'd1, 3'd0, 1'b0, 0, 32'h1040_0110};
    vecs[5] = '{32'hDDCC_BBAA, 2'd0, 2'd0, 3'd7, 1'b0, 8, 32'hDDCC_BBAA};
    vecs[6] = '{32'hFF80_0201, 2'd2, 2'd1, 3'd4, 1'b1, 8, 32'hDECB_3BAC};

    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_dout", {24'd0, DOutB}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    resetn = 1'b1;

    for (int i = 0; i < 7; i++) begin
      w = vecs[i].a;
      for (int j = 0; j < 4; j++) write_a(j[1:0], w[8*j +: 8]);
      run_xfer(vecs[i].src, vecs[i].dst, vecs[i].cnt, vecs[i].mode, e);
      check($sformatf("v%0d_done_edge", i), e, vecs[i].exp_edge);
      @(posedge clock);
      @(negedge clock);
      check($sformatf("v%0d_done_pulse", i), {31'd0, done}, 32'd0);
      check($sformatf("v%0d_busy_fall", i), {31'd0, busy}, 32'd0);
      w = vecs[i].exp_b;
      for (int j = 0; j < 4; j++) begin
        read_b(j[1:0], q);
        check($sformatf("v%0d_B%0d", i, j), {24'd0, q}, {24'd0, w[8*j +: 8]});
      end
    end

    // Mid-clock reset clears outputs without waiting for an edge
    read_b(2'd0, q);
    check("pre_rst_read", {24'd0, q}, 32'h0000_00AC);
    #3 resetn = 1'b0;
    #1;
    check("async_rst_dout", {24'd0, DOutB}, 32'd0);
    check("async_rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clock);
    resetn = 1'b1;

    // Host write and second start ignored while busy; DOutB held
    write_a(2'd0, 8'h11); write_a(2'd1, 8'h22); write_a(2'd2, 8'h33); write_a(2'd3, 8'h44);
    read_b(2'd0, q);
    check("hold_ref", {24'd0, q}, 32'h0000_00AC);
    p0 = done_pulses;
    dout_changes = 0;
    @(negedge clock);
    SrcAddr = 2'd0; DstAddr = 2'd0; Count = 3'd4; Mode = 1'b0; start = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    @(posedge clock);
    @(negedge clock);
    AddrA = 2'd1; DataInA = 8'hAA; WEA = 1'b1;
    start = 1'b1; Count = 3'd1; DstAddr = 2'd3; AddrB = 2'd2;
    repeat (2) begin
      @(posedge clock);
      @(negedge clock);
      if (busy && DOutB !== 8'hAC) dout_changes++;
    end
    WEA = 1'b0; start = 1'b0;
    repeat (12) begin
      @(posedge clock);
      @(negedge clock);
      if (busy && DOutB !== 8'hAC) dout_changes++;
    end
    check("busy_dout_hold", dout_changes, 32'd0);
    check("busy_one_done", done_pulses - p0, 32'd1);
    run_xfer(2'd1, 2'd3, 3'd1, 1'b0, e);
    check("a1_copy_edge", e, 32'd2);
    @(negedge clock);
    read_b(2'd3, q);
    check("a1_protected", {24'd0, q}, 32'h0000_0022);
    read_b(2'd1, q);
    check("busy_copy_B1", {24'd0, q}, 32'h0000_0022);

    // Abort: reset just after edge 3 of a 4-word copy
    write_a(2'd0, 8'h55); write_a(2'd1, 8'h66); write_a(2'd2, 8'h77); write_a(2'd3, 8'h88);
    p0 = done_pulses;
    @(negedge clock);
    SrcAddr = 2'd0; DstAddr = 2'd0; Count = 3'd4; Mode = 1'b0; start = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    repeat (3) @(posedge clock);
    #1 resetn = 1'b0;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_dout", {24'd0, DOutB}, 32'd0);
    @(negedge clock);
    resetn = 1'b1;
    repeat (6) @(negedge clock);
    check("abort_no_done", done_pulses - p0, 32'd0);
    w = 32'h2233_6655;
    for (int j = 0; j < 4; j++) begin
      read_b(j[1:0], q);
      check($sformatf("abort_B%0d", j), {24'd0, q}, {24'd0, w[8*j +: 8]});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
